// File: rtl/time_digit_writer_if.sv
// Write bus from the time digit writer to the downstream segment decoder.
interface time_digit_writer_if;
    logic        oChip_select_n;
    logic        oWrite_n;
    logic [2:0]  oAddress;
    logic [31:0] oData;

    modport master (output oChip_select_n, oWrite_n, oAddress, oData);
    modport slave  (input  oChip_select_n, oWrite_n, oAddress, oData);
endinterface

// File: rtl/time_digit_writer.sv
// Time-of-day counter that streams its six BCD digits to a segment decoder after every change.
// Define TWELVE_HOUR_EN for a 1..12 hour count; otherwise hours run 0..23.
module time_digit_writer (
    input  logic                       iClk,
    input  logic                       iReset_n,
    input  logic                       iTick,
    input  logic                       iLoad,
    input  logic [4:0]                 iLoad_hours,
    input  logic [5:0]                 iLoad_minutes,
    input  logic [5:0]                 iLoad_seconds,
    time_digit_writer_if.master        decoderBus
);
    typedef enum logic {IDLE = 1'b0, WRITE = 1'b1} fsmState_t;

`ifdef TWELVE_HOUR_EN
    localparam logic [4:0] HOUR_FIRST = 5'd1;
    localparam logic [4:0] HOUR_LAST  = 5'd12;
    localparam logic [4:0] HOUR_RESET = 5'd12;
`else
    localparam logic [4:0] HOUR_FIRST = 5'd0;
    localparam logic [4:0] HOUR_LAST  = 5'd23;
    localparam logic [4:0] HOUR_RESET = 5'd0;
`endif
    localparam logic [2:0] LAST_DIGIT = 3'd5;

    logic [4:0]       hours;
    logic [5:0]       minutes;
    logic [5:0]       seconds;
    logic             hoursValid;
    logic             loadAccept;
    logic             timeUpdate;
    logic             pending;
    logic             startSnapshot;
    fsmState_t        state;
    fsmState_t        stateNext;
    logic [2:0]       digitIndex;
    logic [2:0]       digitIndexNext;
    logic [5:0][3:0]  liveDigits;
    logic [5:0][3:0]  snapshot;
    logic [3:0]       currentDigit;

    function automatic logic [7:0] toBcd(input logic [5:0] value);
        logic [3:0] tens;
        logic [3:0] ones;
        tens = 4'(value / 6'd10);
        ones = 4'(value - 6'(tens) * 6'd10);
        return {tens, ones};
    endfunction

`ifdef TWELVE_HOUR_EN
    assign hoursValid = (iLoad_hours >= HOUR_FIRST) && (iLoad_hours <= HOUR_LAST);
`else
    assign hoursValid = (iLoad_hours <= HOUR_LAST);
`endif
    assign loadAccept = iLoad && hoursValid && (iLoad_minutes <= 6'd59) && (iLoad_seconds <= 6'd59);
    // A load strobe always swallows a coincident tick, even when the load itself is rejected.
    assign timeUpdate = loadAccept || (iTick && !iLoad);

    assign liveDigits = {toBcd({1'b0, hours}), toBcd(minutes), toBcd(seconds)};

    always_ff @(posedge iClk or negedge iReset_n) begin
        if (!iReset_n) begin
            hours   <= HOUR_RESET;
            minutes <= 6'd0;
            seconds <= 6'd0;
        end else if (iLoad) begin
            if (loadAccept) begin
                // NOTE: non-blocking assignments keep every register reading pre-edge values.
                hours   <= iLoad_hours;
                minutes <= iLoad_minutes;
                seconds <= iLoad_seconds;
            end
        end else if (iTick) begin
            if (seconds == 6'd59) begin
                seconds <= 6'd0;
                if (minutes == 6'd59) begin
                    minutes <= 6'd0;
                    hours   <= (hours == HOUR_LAST) ? HOUR_FIRST : hours + 5'd1;
                end else begin
                    minutes <= minutes + 6'd1;
                end
            end else begin
                seconds <= seconds + 6'd1;
            end
        end
    end

    always_comb begin
        // NOTE: defaults first so no path leaves a signal unassigned and infers a latch.
        stateNext      = state;
        digitIndexNext = digitIndex;
        startSnapshot  = 1'b0;
        case (state)
            IDLE: begin
                if (pending) begin
                    stateNext      = WRITE;
                    digitIndexNext = 3'd0;
                    startSnapshot  = 1'b1;
                end
            end
            WRITE: begin
                if (digitIndex == LAST_DIGIT) begin
                    if (pending) begin
                        digitIndexNext = 3'd0;
                        startSnapshot  = 1'b1;
                    end else begin
                        stateNext = IDLE;
                    end
                end else begin
                    digitIndexNext = digitIndex + 3'd1;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    // NOTE: the snapshot is reset too, because it drives oData directly and must read 0 in reset.
    always_ff @(posedge iClk or negedge iReset_n) begin
        if (!iReset_n) begin
            state      <= IDLE;
            digitIndex <= 3'd0;
            pending    <= 1'b1;
            snapshot   <= '0;
        end else begin
            state      <= stateNext;
            digitIndex <= digitIndexNext;
            // A change landing on the snapshot edge must survive to trigger the next sequence.
            pending    <= timeUpdate || (pending && !startSnapshot);
            if (startSnapshot) begin
                snapshot <= liveDigits;
            end
        end
    end

    always_comb begin
        currentDigit = 4'd0;
        case (digitIndex)
            3'd0:    currentDigit = snapshot[0];
            3'd1:    currentDigit = snapshot[1];
            3'd2:    currentDigit = snapshot[2];
            3'd3:    currentDigit = snapshot[3];
            3'd4:    currentDigit = snapshot[4];
            3'd5:    currentDigit = snapshot[5];
            default: currentDigit = 4'd0;
        endcase
    end

    // Index and snapshot are frozen outside WRITE, so address and data hold their last values.
    assign decoderBus.oChip_select_n = (state != WRITE);
    assign decoderBus.oWrite_n       = (state != WRITE);
    assign decoderBus.oAddress       = digitIndex;
    assign decoderBus.oData          = {28'd0, currentDigit};
endmodule

// File: tb/tb_time_digit_writer.sv
// Self-checking bench for time_digit_writer: seconds-of-day model plus literal digit sequences.
// Build with TWELVE_HOUR_EN defined to exercise the 12-hour variant.
module tb_time_digit_writer;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       tick;
    logic       load;
    logic [4:0] ldHours;
    logic [5:0] ldMinutes;
    logic [5:0] ldSeconds;

    time_digit_writer_if bus();

    time_digit_writer dut (
        .iClk          (clk),
        .iReset_n      (rst_n),
        .iTick         (tick),
        .iLoad         (load),
        .iLoad_hours   (ldHours),
        .iLoad_minutes (ldMinutes),
        .iLoad_seconds (ldSeconds),
        .decoderBus    (bus)
    );

    always #5 clk = ~clk;

`ifdef TWELVE_HOUR_EN
    localparam int          PERIOD       = 43200;
    localparam bit          TWELVE       = 1'b1;
    localparam logic [23:0] RESET_DIGITS = 24'h120000;
    localparam logic [23:0] WRAP_LOADED  = 24'h125959;
    localparam logic [23:0] WRAP_AFTER   = 24'h010000;
    localparam int          WRAP_TIME    = 3600;
    localparam int          WRAP_HOURS   = 12;
`else
    localparam int          PERIOD       = 86400;
    localparam bit          TWELVE       = 1'b0;
    localparam logic [23:0] RESET_DIGITS = 24'h000000;
    localparam logic [23:0] WRAP_LOADED  = 24'h235959;
    localparam logic [23:0] WRAP_AFTER   = 24'h000000;
    localparam int          WRAP_TIME    = 0;
    localparam int          WRAP_HOURS   = 23;
`endif

    int nChecks = 0;
    int nFails  = 0;

    task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
        nChecks++;
        if (actual !== expected) begin
            nFails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Behavioural model: time as seconds since the start of the hour cycle, writes as a queue.
    int  mTime    = 0;
    bit  mPending = 1'b1;
    int  mQueue[$];
    bit  mWriting = 1'b0;
    int  mAddr    = 0;
    int  mData    = 0;
    int  logQ[$];

    function automatic int digitOf(input int t, input int k);
        int h, m, s;
        h = t / 3600;
        m = (t / 60) % 60;
        s = t % 60;
        if (TWELVE && h == 0) h = 12;
        case (k)
            0:       return s % 10;
            1:       return s / 10;
            2:       return m % 10;
            3:       return m / 10;
            4:       return h % 10;
            default: return h / 10;
        endcase
    endfunction

    function automatic bit loadOk(input int h, input int m, input int s);
        if (m > 59 || s > 59) return 1'b0;
        return TWELVE ? (h >= 1 && h <= 12) : (h <= 23);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mTime    = 0;
            mPending = 1'b1;
            mQueue.delete();
            mWriting = 1'b0;
            mAddr    = 0;
            mData    = 0;
        end else begin
            if (mQueue.size() == 0 && mPending) begin
                for (int k = 0; k < 6; k++) mQueue.push_back((k << 8) | digitOf(mTime, k));
                mPending = 1'b0;
            end
            if (mQueue.size() != 0) begin
                int e;
                e        = mQueue.pop_front();
                mWriting = 1'b1;
                mAddr    = e >> 8;
                mData    = e & 255;
            end else begin
                mWriting = 1'b0;
            end
            if (load) begin
                if (loadOk(int'(ldHours), int'(ldMinutes), int'(ldSeconds))) begin
                    mTime    = (int'(ldHours) % (PERIOD / 3600)) * 3600 + int'(ldMinutes) * 60 + int'(ldSeconds);
                    mPending = 1'b1;
                end
            end else if (tick) begin
                mTime    = (mTime + 1) % PERIOD;
                mPending = 1'b1;
            end
        end
    end

    // Compare process: every cycle, on the falling edge.
    always @(negedge clk) begin
        logic [36:0] act, exp;
        act = {bus.oChip_select_n, bus.oWrite_n, bus.oAddress, bus.oData};
        exp = {~mWriting, ~mWriting, mAddr[2:0], mData[31:0]};
        check("bus", 64'(act), 64'(exp));
        if (bus.oChip_select_n === 1'b0) logQ.push_back((int'(bus.oAddress) << 8) | int'(bus.oData[7:0]));
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic doLoad(input int h, input int m, input int s);
        load      = 1'b1;
        ldHours   = 5'(h);
        ldMinutes = 6'(m);
        ldSeconds = 6'(s);
        idle(1);
        load = 1'b0;
    endtask

    task automatic doTick();
        tick = 1'b1;
        idle(1);
        tick = 1'b0;
    endtask

    task automatic expectSeq(input string name, input int start, input logic [23:0] digits);
        for (int k = 0; k < 6; k++) begin
            if (start + k < logQ.size()) begin
                check(name, 64'(logQ[start + k]), 64'((k << 8) | int'(digits[4*k +: 4])));
            end else begin
                check({name, " missing"}, 64'(logQ.size()), 64'(start + k + 1));
            end
        end
    endtask

    task automatic waitWrite(input logic [2:0] addr);
        bit found;
        found = 1'b0;
        for (int n = 0; n < 50 && !found; n++) begin
            @(negedge clk);
            if (bus.oChip_select_n === 1'b0 && bus.oAddress === addr) found = 1'b1;
        end
        check("wait for write", 64'(found), 64'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0; tick = 1'b0; load = 1'b0;
        ldHours = '0; ldMinutes = '0; ldSeconds = '0;
        idle(3);
        logQ.delete();
        rst_n = 1'b1;

        // Reset release writes the reset time, then idles holding the last digit.
        idle(10);
        check("reset seq count", 64'(logQ.size()), 64'd6);
        expectSeq("reset seq", 0, RESET_DIGITS);
        check("idle hold", {61'd0, bus.oChip_select_n, bus.oAddress}, {61'd1, 3'd5});
        check("idle data", 64'(bus.oData), 64'(RESET_DIGITS[23:20]));

        // Full-day wrap in one tick.
        logQ.delete();
        doLoad(WRAP_HOURS, 59, 59);
        idle(10);
        doTick();
        idle(10);
        check("wrap count", 64'(logQ.size()), 64'd12);
        expectSeq("wrap loaded", 0, WRAP_LOADED);
        expectSeq("wrap after", 6, WRAP_AFTER);
        check("model wrap time", 64'(mTime), 64'(WRAP_TIME));

        // Load to first write latency from IDLE.
        logQ.delete();
        load = 1'b1; ldHours = 5'd12; ldMinutes = 6'd34; ldSeconds = 6'd56;
        @(negedge clk);
        @(posedge clk); #1;
        load = 1'b0;
        @(negedge clk);
        check("latency cycle 1", 64'(bus.oChip_select_n), 64'd1);
        @(negedge clk);
        check("latency cycle 2", {60'd0, bus.oChip_select_n, bus.oAddress}, 64'd0);
        @(posedge clk); #1;
        idle(8);
        check("12:34:56 count", 64'(logQ.size()), 64'd6);
        expectSeq("12:34:56", 0, 24'h123456);

        // Out-of-range loads are ignored entirely.
        logQ.delete();
        doLoad(12, 60, 0);
        idle(10);
        doLoad(24, 0, 0);
        idle(10);
        check("invalid load quiet", 64'(logQ.size()), 64'd0);
        doTick();
        idle(10);
        expectSeq("time kept", 0, 24'h123457);

        // Tick during the address-2 write: old digits finish, then exactly one fresh sequence.
        logQ.delete();
        doLoad(12, 34, 56);
        waitWrite(3'd2);
        tick = 1'b1;
        @(posedge clk); #1;
        tick = 1'b0;
        idle(20);
        check("mid tick count", 64'(logQ.size()), 64'd12);
        expectSeq("mid tick old", 0, 24'h123456);
        expectSeq("mid tick new", 6, 24'h123457);

        // Reset mid-sequence aborts at once.
        logQ.delete();
        doLoad(12, 34, 56);
        waitWrite(3'd3);
        #1 rst_n = 1'b0;
        #1 check("reset abort", {59'd0, bus.oChip_select_n, bus.oWrite_n, bus.oAddress}, {59'd0, 2'b11, 3'd0});
        @(posedge clk); #1;
        idle(2);
        rst_n = 1'b1;
        idle(10);
        check("abort count", 64'(logQ.size()), 64'd10);
        expectSeq("after abort", 4, RESET_DIGITS);

        // Random ticks and loads (some invalid), checked by the model every cycle.
        repeat (3000) begin
            tick      = ($urandom_range(0, 3) == 0);
            load      = ($urandom_range(0, 39) == 0);
            ldHours   = 5'($urandom_range(0, 31));
            ldMinutes = 6'($urandom_range(0, 63));
            ldSeconds = 6'($urandom_range(0, 63));
            idle(1);
        end
        tick = 1'b0;
        load = 1'b0;
        idle(20);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end
endmodule
